// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_sequencer
// Description : Program-counter and sequencing stage feeding the control
//               decoder. Holds the ROM address (ProgCtr) and the per-
//               instruction decode context (mode, previous instruction,
//               compare flags), applies the decoder's branch / mode / halt
//               outputs every clock, and runs a Start/Ack handshake.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: FETCH_PERF_EN
//   defined   -> adds CycleCnt / BranchCnt saturating performance counters
//   undefined -> counters and their ports are absent
// ----------------------------------------------------------------------------
// Parameters:
//   PC_W      program counter width (>= 9)
//   RESET_PC  PC loaded on reset and on every program start
// Ports:
//   Clk, Reset          clock (rising edge), synchronous active-high reset
//   Start               start/abort request (level)
//   Stall               freeze all RUN state this cycle
//   BranchEn/Target     decoder branch request, absolute 9-bit destination
//   NextState           decoder mode for the next instruction
//   PrevInstructionIn   instruction word the decoder wants retained
//   CMPBitsIn/LoadEn    new compare flags {zero, equal, gt} and load strobe
//   Ack                 decoder signals end of program
//   ProgCtr             instruction ROM address
//   CurrState           decode mode (00 reg, 01 target, 10 imm, 11 unused)
//   PrevInstruction     retained instruction
//   CMPBits             retained compare flags
//   Running / Done      registered decodes of RUN / HALT
//   CycleCnt/BranchCnt  (FETCH_PERF_EN only) non-stalled RUN cycles, branches
// ============================================================================
module fetch_sequencer #(
    parameter int unsigned PC_W     = 10,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Stall,
    input  logic            BranchEn,
    input  logic [8:0]      BranchTarget,
    input  logic [1:0]      NextState,
    input  logic [8:0]      PrevInstructionIn,
    input  logic [2:0]      CMPBitsIn,
    input  logic            CMPLoadEn,
    input  logic            Ack,
    output logic [PC_W-1:0] ProgCtr,
    output logic [1:0]      CurrState,
    output logic [8:0]      PrevInstruction,
    output logic [2:0]      CMPBits,
    output logic            Running,
    output logic            Done
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]     CycleCnt,
    output logic [15:0]     BranchCnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [PC_W-1:0] c_reset_pc = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] c_pc_one   = PC_W'(1);

    state_t          state_q;
    logic [PC_W-1:0] prog_ctr_q;
    logic [1:0]      curr_state_q;
    logic [8:0]      prev_instr_q;
    logic [2:0]      cmp_bits_q;
    logic            running_q;
    logic            done_q;

    // A non-stalled RUN cycle: the only cycle type in which RUN may act.
    logic w_run_active;
    // Any transition into ARMED (from IDLE, an aborted RUN, or HALT).
    logic w_enter_armed;
    // Next sequential PC; the branch target is zero-extended to PC_W.
    logic [PC_W-1:0] w_pc_next;

    always_comb begin
        w_run_active  = (state_q == ST_RUN) && !Stall;
        w_enter_armed = ((state_q == ST_IDLE) && Start) ||
                        (w_run_active && Start) ||
                        ((state_q == ST_HALT) && Start);
        w_pc_next     = BranchEn ? PC_W'(BranchTarget) : (prog_ctr_q + c_pc_one);
    end

    // ------------------------------------------------------------------------
    // Sequencing FSM with registered outputs. Running/Done are loaded with
    // the decode of the state being entered so they line up with state_q.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            prog_ctr_q   <= c_reset_pc;
            curr_state_q <= 2'b00;
            prev_instr_q <= 9'd0;
            cmp_bits_q   <= 3'b000;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
        end else if (w_enter_armed) begin
            // Program (re)start: rewind PC and wipe the decode context.
            state_q      <= ST_ARMED;
            prog_ctr_q   <= c_reset_pc;
            curr_state_q <= 2'b00;
            prev_instr_q <= 9'd0;
            cmp_bits_q   <= 3'b000;
            running_q    <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    // Waiting for Start; handled by w_enter_armed.
                end
                ST_ARMED: begin
                    prog_ctr_q   <= c_reset_pc;
                    curr_state_q <= 2'b00;
                    prev_instr_q <= 9'd0;
                    cmp_bits_q   <= 3'b000;
                    // Launch on the first cycle Start is released.
                    if (!Start) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    // Stall freezes everything; Start was handled above.
                    if (!Stall) begin
                        if (Ack) begin
                            // Ack wins over a simultaneous branch: PC and
                            // context are frozen for inspection in HALT.
                            state_q   <= ST_HALT;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
                        end else begin
                            prog_ctr_q   <= w_pc_next;
                            curr_state_q <= NextState;
                            prev_instr_q <= PrevInstructionIn;
                            if (CMPLoadEn) begin
                                cmp_bits_q <= CMPBitsIn;
                            end
                        end
                    end
                end
                ST_HALT: begin
                    // Hold until Start re-arms (w_enter_armed).
                end
                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign ProgCtr         = prog_ctr_q;
    assign CurrState       = curr_state_q;
    assign PrevInstruction = prev_instr_q;
    assign CMPBits         = cmp_bits_q;
    assign Running         = running_q;
    assign Done            = done_q;

`ifdef FETCH_PERF_EN
    // ------------------------------------------------------------------------
    // Saturating performance counters. The abort cycle (Start in RUN) is
    // a non-stalled RUN cycle but lands in ARMED, so the clear wins.
    // ------------------------------------------------------------------------
    logic [15:0] cycle_cnt_q;
    logic [15:0] branch_cnt_q;

    always_ff @(posedge Clk) begin
        if (Reset || w_enter_armed) begin
            cycle_cnt_q  <= 16'd0;
            branch_cnt_q <= 16'd0;
        end else if (w_run_active) begin
            if (cycle_cnt_q != 16'hFFFF) begin
                cycle_cnt_q <= cycle_cnt_q + 16'd1;
            end
            if (BranchEn && !Ack && (branch_cnt_q != 16'hFFFF)) begin
                branch_cnt_q <= branch_cnt_q + 16'd1;
            end
        end
    end

    assign CycleCnt  = cycle_cnt_q;
    assign BranchCnt = branch_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_sequencer
// Description : Directed self-checking bench for fetch_sequencer. Inputs are
//               driven 1 ns after a rising edge and outputs are sampled at
//               that same point, i.e. reflecting the edge just taken.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_sequencer;

    localparam int PC_W = 10;

    logic            Clk;
    logic            Reset;
    logic            Start;
    logic            Stall;
    logic            BranchEn;
    logic [8:0]      BranchTarget;
    logic [1:0]      NextState;
    logic [8:0]      PrevInstructionIn;
    logic [2:0]      CMPBitsIn;
    logic            CMPLoadEn;
    logic            Ack;
    logic [PC_W-1:0] ProgCtr;
    logic [1:0]      CurrState;
    logic [8:0]      PrevInstruction;
    logic [2:0]      CMPBits;
    logic            Running;
    logic            Done;
`ifdef FETCH_PERF_EN
    logic [15:0]     CycleCnt;
    logic [15:0]     BranchCnt;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    fetch_sequencer #(
        .PC_W     (PC_W),
        .RESET_PC (0)
    ) dut (
        .Clk               (Clk),
        .Reset             (Reset),
        .Start             (Start),
        .Stall             (Stall),
        .BranchEn          (BranchEn),
        .BranchTarget      (BranchTarget),
        .NextState         (NextState),
        .PrevInstructionIn (PrevInstructionIn),
        .CMPBitsIn         (CMPBitsIn),
        .CMPLoadEn         (CMPLoadEn),
        .Ack               (Ack),
        .ProgCtr           (ProgCtr),
        .CurrState         (CurrState),
        .PrevInstruction   (PrevInstruction),
        .CMPBits           (CMPBits),
        .Running           (Running),
        .Done              (Done)
`ifdef FETCH_PERF_EN
        ,
        .CycleCnt          (CycleCnt),
        .BranchCnt         (BranchCnt)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Re-arm and launch: after this ProgCtr = 0 in the first RUN cycle.
    task automatic restart_run();
        Start = 1'b1; step();
        Start = 1'b0; step();
    endtask

    task automatic test_reset();
        Reset = 1'b1; step(); step();
        tests_run++; if (ProgCtr !== 10'h000) begin tests_failed++; $display("FAIL reset_pc: got %h want 000", ProgCtr); end
        tests_run++; if (CurrState !== 2'b00) begin tests_failed++; $display("FAIL reset_state: got %b want 00", CurrState); end
        tests_run++; if (PrevInstruction !== 9'h000) begin tests_failed++; $display("FAIL reset_prev: got %h want 000", PrevInstruction); end
        tests_run++; if (CMPBits !== 3'b000) begin tests_failed++; $display("FAIL reset_cmp: got %b want 000", CMPBits); end
        tests_run++; if (Running !== 1'b0) begin tests_failed++; $display("FAIL reset_running: got %b want 0", Running); end
        tests_run++; if (Done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", Done); end
        Reset = 1'b0;
    endtask

    task automatic test_start_run();
        Start = 1'b1; step();   // IDLE -> ARMED
        tests_run++; if (Running !== 1'b0) begin tests_failed++; $display("FAIL armed_running: got %b want 0", Running); end
        step();                 // stays ARMED while Start held
        Start = 1'b0; step();   // ARMED -> RUN
        tests_run++; if (Running !== 1'b1) begin tests_failed++; $display("FAIL run_running: got %b want 1", Running); end
        for (int i = 0; i < 4; i++) begin
            tests_run++; if (ProgCtr !== PC_W'(i)) begin tests_failed++; $display("FAIL seq_pc[%0d]: got %h want %h", i, ProgCtr, PC_W'(i)); end
            step();
        end
        // ProgCtr is now 4
    endtask

    task automatic test_branch();
        step();                 // ProgCtr = 5
        tests_run++; if (ProgCtr !== 10'h005) begin tests_failed++; $display("FAIL pre_branch_pc: got %h want 005", ProgCtr); end
        BranchEn = 1'b1; BranchTarget = 9'h1F3; step();
        BranchEn = 1'b0; BranchTarget = 9'h000;
        tests_run++; if (ProgCtr !== 10'h1F3) begin tests_failed++; $display("FAIL branch_pc: got %h want 1f3", ProgCtr); end
`ifdef FETCH_PERF_EN
        tests_run++; if (BranchCnt !== 16'd1) begin tests_failed++; $display("FAIL branch_cnt: got %0d want 1", BranchCnt); end
`endif
        step();
        tests_run++; if (ProgCtr !== 10'h1F4) begin tests_failed++; $display("FAIL post_branch_pc: got %h want 1f4", ProgCtr); end
    endtask

    task automatic test_mode();
        restart_run();
        for (int i = 0; i < 7; i++) step();   // ProgCtr = 7
        tests_run++; if (ProgCtr !== 10'h007) begin tests_failed++; $display("FAIL mode_pre_pc: got %h want 007", ProgCtr); end
        NextState = 2'b01; PrevInstructionIn = 9'h10C; step();
        NextState = 2'b00; PrevInstructionIn = 9'h000;
        tests_run++; if (CurrState !== 2'b01) begin tests_failed++; $display("FAIL mode_state: got %b want 01", CurrState); end
        tests_run++; if (PrevInstruction !== 9'h10C) begin tests_failed++; $display("FAIL mode_prev: got %h want 10c", PrevInstruction); end
        tests_run++; if (ProgCtr !== 10'h008) begin tests_failed++; $display("FAIL mode_pc: got %h want 008", ProgCtr); end
        step();
        tests_run++; if (CurrState !== 2'b00) begin tests_failed++; $display("FAIL mode_second_word: got %b want 00", CurrState); end
    endtask

    task automatic test_cmp();
        CMPLoadEn = 1'b1; CMPBitsIn = 3'b011; step();
        tests_run++; if (CMPBits !== 3'b011) begin tests_failed++; $display("FAIL cmp_load: got %b want 011", CMPBits); end
        CMPLoadEn = 1'b0; CMPBitsIn = 3'b100; step();
        tests_run++; if (CMPBits !== 3'b011) begin tests_failed++; $display("FAIL cmp_hold1: got %b want 011", CMPBits); end
        step();
        tests_run++; if (CMPBits !== 3'b011) begin tests_failed++; $display("FAIL cmp_hold2: got %b want 011", CMPBits); end
        CMPBitsIn = 3'b000;
    endtask

    task automatic test_abort();
        NextState = 2'b10; PrevInstructionIn = 9'h1AB; CMPLoadEn = 1'b1; CMPBitsIn = 3'b111; step();
        NextState = 2'b00; PrevInstructionIn = 9'h000; CMPLoadEn = 1'b0; CMPBitsIn = 3'b000;
        tests_run++; if (CurrState !== 2'b10) begin tests_failed++; $display("FAIL abort_pre_state: got %b want 10", CurrState); end
        Start = 1'b1; step();   // RUN -> ARMED
        tests_run++; if (ProgCtr !== 10'h000) begin tests_failed++; $display("FAIL abort_pc: got %h want 000", ProgCtr); end
        tests_run++; if (CurrState !== 2'b00) begin tests_failed++; $display("FAIL abort_state: got %b want 00", CurrState); end
        tests_run++; if (PrevInstruction !== 9'h000) begin tests_failed++; $display("FAIL abort_prev: got %h want 000", PrevInstruction); end
        tests_run++; if (CMPBits !== 3'b000) begin tests_failed++; $display("FAIL abort_cmp: got %b want 000", CMPBits); end
        tests_run++; if (Running !== 1'b0) begin tests_failed++; $display("FAIL abort_running: got %b want 0", Running); end
        Start = 1'b0; step();   // back to RUN at PC 0
    endtask

    task automatic test_ack_halt();
        BranchEn = 1'b1; BranchTarget = 9'h020; step();
        tests_run++; if (ProgCtr !== 10'h020) begin tests_failed++; $display("FAIL ack_pre_pc: got %h want 020", ProgCtr); end
        Ack = 1'b1; BranchEn = 1'b1; BranchTarget = 9'h055; step();
        Ack = 1'b0; BranchEn = 1'b0; BranchTarget = 9'h000;
        tests_run++; if (ProgCtr !== 10'h020) begin tests_failed++; $display("FAIL ack_pc: got %h want 020", ProgCtr); end
        tests_run++; if (Done !== 1'b1) begin tests_failed++; $display("FAIL ack_done: got %b want 1", Done); end
        tests_run++; if (Running !== 1'b0) begin tests_failed++; $display("FAIL ack_running: got %b want 0", Running); end
        step();
        tests_run++; if (ProgCtr !== 10'h020) begin tests_failed++; $display("FAIL halt_hold_pc: got %h want 020", ProgCtr); end
        Start = 1'b1; step();
        tests_run++; if (Done !== 1'b0) begin tests_failed++; $display("FAIL rearm_done: got %b want 0", Done); end
        Start = 1'b0; step();
        tests_run++; if (ProgCtr !== 10'h000) begin tests_failed++; $display("FAIL restart_pc: got %h want 000", ProgCtr); end
        tests_run++; if (Running !== 1'b1) begin tests_failed++; $display("FAIL restart_running: got %b want 1", Running); end
`ifdef FETCH_PERF_EN
        tests_run++; if (BranchCnt !== 16'd0) begin tests_failed++; $display("FAIL restart_branch_cnt: got %0d want 0", BranchCnt); end
        tests_run++; if (CycleCnt !== 16'd0) begin tests_failed++; $display("FAIL restart_cycle_cnt: got %0d want 0", CycleCnt); end
`endif
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) step();   // ProgCtr = 4
        tests_run++; if (ProgCtr !== 10'h004) begin tests_failed++; $display("FAIL stall_pre_pc: got %h want 004", ProgCtr); end
        Stall = 1'b1; BranchEn = 1'b1; BranchTarget = 9'h100;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++; if (ProgCtr !== 10'h004) begin tests_failed++; $display("FAIL stall_pc[%0d]: got %h want 004", i, ProgCtr); end
        end
        Stall = 1'b0; BranchEn = 1'b0; BranchTarget = 9'h000; step();
        tests_run++; if (ProgCtr !== 10'h005) begin tests_failed++; $display("FAIL stall_release_pc: got %h want 005", ProgCtr); end
`ifdef FETCH_PERF_EN
        tests_run++; if (CycleCnt !== 16'd5) begin tests_failed++; $display("FAIL stall_cycle_cnt: got %0d want 5", CycleCnt); end
        tests_run++; if (BranchCnt !== 16'd0) begin tests_failed++; $display("FAIL stall_branch_cnt: got %0d want 0", BranchCnt); end
`endif
    endtask

    task automatic test_wrap();
        BranchEn = 1'b1; BranchTarget = 9'h1FF; step();
        BranchEn = 1'b0; BranchTarget = 9'h000;
        for (int i = 0; i < 512; i++) step();   // 0x1FF + 0x200 = 0x3FF
        tests_run++; if (ProgCtr !== 10'h3FF) begin tests_failed++; $display("FAIL wrap_pre_pc: got %h want 3ff", ProgCtr); end
        step();
        tests_run++; if (ProgCtr !== 10'h000) begin tests_failed++; $display("FAIL wrap_pc: got %h want 000", ProgCtr); end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; Stall = 1'b0; BranchEn = 1'b0;
        BranchTarget = 9'h000; NextState = 2'b00; PrevInstructionIn = 9'h000;
        CMPBitsIn = 3'b000; CMPLoadEn = 1'b0; Ack = 1'b0;
        test_reset();
        test_start_run();
        test_branch();
        test_mode();
        test_cmp();
        test_abort();
        test_ack_halt();
        test_stall();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program-counter and sequencing stage directly upstream of the control decoder. Holds the program counter that addresses instruction ROM, plus the per-instruction context the decoder consumes next cycle: current decode mode, previous instruction, and compare flags. Applies the decoder's branch, mode and halt outputs each clock. Runs a start/halt handshake with the testbench.

## Interface
Parameters:
- PC_W, 10, program counter width; must be ≥ 9.
- RESET_PC, 0, PC value loaded on reset and on every program start.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  testbench start request, level.
- Stall  input  1  freeze all state this cycle.
- BranchEn  input  1  decoder: take branch this cycle.
- BranchTarget  input  9  decoder: absolute branch destination.
- NextState  input  2  decoder: decode mode for next instruction.
- PrevInstructionIn  input  9  decoder: instruction to retain.
- CMPBitsIn  input  3  new compare flags {zero, equal, gt}.
- CMPLoadEn  input  1  load CMPBitsIn.
- Ack  input  1  decoder: program done.
- ProgCtr  output  PC_W  instruction ROM address.
- CurrState  output  2  decode mode to decoder (00 regular, 01 target, 10 immediate, 11 unused).
- PrevInstruction  output  9  retained instruction to decoder.
- CMPBits  output  3  retained compare flags to decoder.
- Running  output  1  high while in RUN.
- Done  output  1  high while in HALT.

## Operation
- FSM states: IDLE, ARMED, RUN, HALT. Reset has priority over all inputs and forces IDLE.
- Reset values: ProgCtr = RESET_PC, CurrState = 00, PrevInstruction = 0, CMPBits = 000, Running = 0, Done = 0.
- IDLE: go to ARMED when Start = 1.
- ARMED: hold ProgCtr = RESET_PC and clear CurrState, PrevInstruction and CMPBits. Go to RUN on the first cycle with Start = 0.
- RUN, Stall = 1: every register holds, including the FSM state. BranchEn, Ack and CMPLoadEn are ignored.
- RUN, Start = 1: abort to ARMED. ProgCtr = RESET_PC and context is cleared.
- RUN, Ack = 1: go to HALT. ProgCtr and context hold. Ack takes priority over BranchEn in the same cycle.
- RUN, otherwise:
  - ProgCtr ← BranchEn ? zero-extended BranchTarget : ProgCtr + 1.
  - CurrState ← NextState; PrevInstruction ← PrevInstructionIn.
  - CMPBits ← CMPBitsIn when CMPLoadEn = 1, else hold.
- Increment is modulo 2^PC_W: all-ones wraps to 0.
- HALT: all registers hold and Done = 1. Go to ARMED when Start = 1.
- Running and Done are registered decodes of the FSM state.

## Timing
- ProgCtr is registered. ROM and decoder are combinational off ProgCtr and the context registers in the same cycle.
- A decoder output presented in cycle N takes effect at edge N+1. A branch target appears on ProgCtr one cycle after BranchEn.
- A two-word instruction (target or immediate mode) occupies two consecutive RUN cycles, absent Stall. CurrState is nonzero only during the second cycle.
- Done rises one cycle after the Ack cycle.
- Running rises one cycle after Start falls in ARMED.
- Stall adds exactly one cycle per stalled cycle, with no lost or duplicated fetch.

## Configuration
- FETCH_PERF_EN defined: adds two output ports.
  - CycleCnt (16): counts non-stalled RUN cycles.
  - BranchCnt (16): counts taken branches, i.e. BranchEn = 1 in non-stalled RUN cycles without Ack.
  - Both saturate at 0xFFFF and clear on reset and on entry to ARMED.
- FETCH_PERF_EN undefined: the ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, Start 1 for 2 cycles then 0, no branches: ProgCtr reads 0, 1, 2, 3 on successive cycles; Running = 1 from the cycle after Start falls.
- At ProgCtr = 5, BranchEn = 1, BranchTarget = 9'h1F3: next ProgCtr = 0x1F3, then 0x1F4. With FETCH_PERF_EN, BranchCnt = 1.
- NextState = 01 with PrevInstructionIn = 9'h10C at ProgCtr = 7: next cycle CurrState = 01, PrevInstruction = 0x10C, ProgCtr = 8.
- CMPLoadEn = 1 with CMPBitsIn = 3'b011, then CMPLoadEn = 0 with CMPBitsIn = 3'b100: CMPBits = 011 and holds.
- Ack and BranchEn together at ProgCtr = 0x20: ProgCtr stays 0x20 and Done = 1 next cycle. Then Start 1→0: ProgCtr = 0 and Running = 1.
- Stall held 3 cycles at ProgCtr = 4 with BranchEn = 1: ProgCtr stays 4 for 3 cycles and no branch is taken.
- ProgCtr = 0x3FF with PC_W = 10, no branch: ProgCtr wraps to 0.
